// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the MEM/WB pipeline buffer:
//   - default widths DATA_W, REG_ADDR_W, PC_W
//   - wb_entry_t : packed {regwrite, data, rd, pc} write-back entry
//   - WB_ENTRY_EMPTY : all-zero entry used for cleared slots
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int PC_W       = 32;

  typedef struct packed {
    logic                  regwrite;
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] rd;
    logic [PC_W-1:0]       pc;
  } wb_entry_t;

  localparam wb_entry_t WB_ENTRY_EMPTY = '0;

endpackage

// File: rtl/wb_bypass_match.sv
// -----------------------------------------------------------------------------
// wb_bypass_match
// Youngest-first write-back bypass lookup over the two buffer entries.
// The tail (younger) entry wins over the head when both match. A lookup
// of register 0 never hits. Data is 0 on a miss.
// Ports:
//   head_valid_i/head_regwrite_i/head_reg_i/head_data_i : head entry
//   tail_valid_i/tail_regwrite_i/tail_reg_i/tail_data_i : tail entry
//   lookup_reg_i : register being looked up
//   hit_o, data_o : lookup result
// Only instantiated when WB_BYPASS_EN is defined.
// -----------------------------------------------------------------------------
module wb_bypass_match #(
  parameter int DATA_W     = wb_pkg::DATA_W,
  parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W
) (
  input  logic                  head_valid_i,
  input  logic                  head_regwrite_i,
  input  logic [REG_ADDR_W-1:0] head_reg_i,
  input  logic [DATA_W-1:0]     head_data_i,
  input  logic                  tail_valid_i,
  input  logic                  tail_regwrite_i,
  input  logic [REG_ADDR_W-1:0] tail_reg_i,
  input  logic [DATA_W-1:0]     tail_data_i,
  input  logic [REG_ADDR_W-1:0] lookup_reg_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     data_o
);

  logic head_match_s;
  logic tail_match_s;
  logic lookup_nz_s;

  assign lookup_nz_s  = (lookup_reg_i != {REG_ADDR_W{1'b0}});
  assign head_match_s = head_valid_i & head_regwrite_i & (head_reg_i == lookup_reg_i);
  assign tail_match_s = tail_valid_i & tail_regwrite_i & (tail_reg_i == lookup_reg_i);

  // Priority select: tail holds the youngest result, so it is checked first.
  always_comb begin
    hit_o  = 1'b0;
    data_o = {DATA_W{1'b0}};
    if (!lookup_nz_s) begin
      hit_o  = 1'b0;
      data_o = {DATA_W{1'b0}};
    end else if (tail_match_s) begin
      hit_o  = 1'b1;
      data_o = tail_data_i;
    end else if (head_match_s) begin
      hit_o  = 1'b1;
      data_o = head_data_i;
    end else begin
      hit_o  = 1'b0;
      data_o = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/wb_pipe_buffer.sv
// -----------------------------------------------------------------------------
// wb_pipe_buffer
// MEM/WB pipeline stage built as a 2-entry elastic buffer (head + tail) with
// valid/ready handshakes, synchronous flush and zero-register suppression.
// All state changes on the FALLING edge of Clk; Reset_n is asynchronous,
// active-low.
// Ports:
//   Clk, Reset_n                     : clock (falling edge), async reset
//   in_valid/in_ready                : upstream handshake
//   regwriteIn/writeDataIn/registerIn/PCNEWIn : incoming entry
//   flush                            : drop buffered and incoming entries
//   out_valid/out_ready              : downstream handshake
//   regwriteOut/writeDataOut/registerOut/PCNEWOut : head entry (0 when empty)
//   count                            : occupancy 0..2
//   bypassRegIn/bypassHit/bypassDataOut : bypass lookup (WB_BYPASS_EN only)
// Configuration macro: WB_BYPASS_EN enables the bypass lookup ports/logic.
// -----------------------------------------------------------------------------
module wb_pipe_buffer #(
  parameter int DATA_W     = wb_pkg::DATA_W,
  parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W,
  parameter int PC_W       = wb_pkg::PC_W
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  regwriteIn,
  input  logic [DATA_W-1:0]     writeDataIn,
  input  logic [REG_ADDR_W-1:0] registerIn,
  input  logic [PC_W-1:0]       PCNEWIn,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  regwriteOut,
  output logic [DATA_W-1:0]     writeDataOut,
  output logic [REG_ADDR_W-1:0] registerOut,
  output logic [PC_W-1:0]       PCNEWOut,
`ifdef WB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] bypassRegIn,
  output logic                  bypassHit,
  output logic [DATA_W-1:0]     bypassDataOut,
`endif
  output logic [1:0]            count
);

  // Entry layout mirrors wb_pkg::wb_entry_t but follows this instance's widths.
  typedef struct packed {
    logic                  regwrite;
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] rd;
    logic [PC_W-1:0]       pc;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '0;

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;

  entry_t     new_entry_s;
  logic       accept_s;
  logic       release_s;
  logic       out_valid_s;

  // Readiness comes from occupancy only, so there is no out_ready -> in_ready path.
  assign in_ready    = (count_q != 2'd2);
  assign out_valid_s = (count_q != 2'd0);
  assign accept_s    = in_valid & in_ready;
  assign release_s   = out_valid_s & out_ready;

  // Incoming entry; a write to register 0 is demoted to a bubble.
  always_comb begin
    new_entry_s          = ENTRY_EMPTY;
    new_entry_s.regwrite = regwriteIn & (registerIn != {REG_ADDR_W{1'b0}});
    new_entry_s.data     = writeDataIn;
    new_entry_s.rd       = registerIn;
    new_entry_s.pc       = PCNEWIn;
  end

  // Occupancy transitions; flush beats any accept/release in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = ENTRY_EMPTY;
      tail_d  = ENTRY_EMPTY;
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (accept_s) begin
            head_d  = new_entry_s;
            count_d = 2'd1;
          end else begin
            count_d = 2'd0;
          end
        end
        2'd1: begin
          case ({accept_s, release_s})
            2'b10: begin
              tail_d  = new_entry_s;
              count_d = 2'd2;
            end
            2'b01: begin
              head_d  = ENTRY_EMPTY;
              count_d = 2'd0;
            end
            2'b11: begin
              head_d  = new_entry_s;
              count_d = 2'd1;
            end
            default: begin
              count_d = 2'd1;
            end
          endcase
        end
        2'd2: begin
          // in_ready is low here, so only a release can happen.
          if (release_s) begin
            head_d  = tail_q;
            tail_d  = ENTRY_EMPTY;
            count_d = 2'd1;
          end else begin
            count_d = 2'd2;
          end
        end
        default: begin
          head_d  = ENTRY_EMPTY;
          tail_d  = ENTRY_EMPTY;
          count_d = 2'd0;
        end
      endcase
    end
  end

  // Buffer state registers, updated on the falling edge.
  always_ff @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_q  <= ENTRY_EMPTY;
      tail_q  <= ENTRY_EMPTY;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Head presentation; forced to zero whenever the buffer is empty.
  always_comb begin
    regwriteOut  = 1'b0;
    writeDataOut = {DATA_W{1'b0}};
    registerOut  = {REG_ADDR_W{1'b0}};
    PCNEWOut     = {PC_W{1'b0}};
    if (out_valid_s) begin
      regwriteOut  = head_q.regwrite;
      writeDataOut = head_q.data;
      registerOut  = head_q.rd;
      PCNEWOut     = head_q.pc;
    end else begin
      regwriteOut  = 1'b0;
      writeDataOut = {DATA_W{1'b0}};
      registerOut  = {REG_ADDR_W{1'b0}};
      PCNEWOut     = {PC_W{1'b0}};
    end
  end

  assign out_valid = out_valid_s;
  assign count     = count_q;

`ifdef WB_BYPASS_EN
  wb_bypass_match #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_bypass (
    .head_valid_i    (count_q != 2'd0),
    .head_regwrite_i (head_q.regwrite),
    .head_reg_i      (head_q.rd),
    .head_data_i     (head_q.data),
    .tail_valid_i    (count_q == 2'd2),
    .tail_regwrite_i (tail_q.regwrite),
    .tail_reg_i      (tail_q.rd),
    .tail_data_i     (tail_q.data),
    .lookup_reg_i    (bypassRegIn),
    .hit_o           (bypassHit),
    .data_o          (bypassDataOut)
  );
`endif

endmodule

// File: tb/tb_wb_pipe_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_pipe_buffer
// Self-checking bench for wb_pipe_buffer: directed vector table, reset and
// bypass sequences, then randomized traffic against a queue-based model.
// Inputs change 1 time unit after the rising edge; the DUT updates on the
// falling edge; outputs are compared 1 time unit after the following rising
// edge.
// -----------------------------------------------------------------------------
module tb_wb_pipe_buffer;
  import wb_pkg::*;

  logic                  Clk;
  logic                  Reset_n;
  logic                  in_valid;
  logic                  in_ready;
  logic                  regwriteIn;
  logic [DATA_W-1:0]     writeDataIn;
  logic [REG_ADDR_W-1:0] registerIn;
  logic [PC_W-1:0]       PCNEWIn;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic                  regwriteOut;
  logic [DATA_W-1:0]     writeDataOut;
  logic [REG_ADDR_W-1:0] registerOut;
  logic [PC_W-1:0]       PCNEWOut;
  logic [1:0]            count;
`ifdef WB_BYPASS_EN
  logic [REG_ADDR_W-1:0] bypassRegIn;
  logic                  bypassHit;
  logic [DATA_W-1:0]     bypassDataOut;
`endif

  int checks;
  int errors;

  // Reference model: ordered list of buffered entries, oldest first.
  wb_entry_t mq[$];

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic        rw;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  e_cnt;
    logic        e_rdy;
    logic        e_rw;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[12];

  wb_pipe_buffer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .regwriteIn   (regwriteIn),
    .writeDataIn  (writeDataIn),
    .registerIn   (registerIn),
    .PCNEWIn      (PCNEWIn),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .regwriteOut  (regwriteOut),
    .writeDataOut (writeDataOut),
    .registerOut  (registerOut),
    .PCNEWOut     (PCNEWOut),
`ifdef WB_BYPASS_EN
    .bypassRegIn  (bypassRegIn),
    .bypassHit    (bypassHit),
    .bypassDataOut(bypassDataOut),
`endif
    .count        (count)
  );

  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic iv, input logic ordy, input logic fl, input logic rw,
                        input logic [31:0] data, input logic [4:0] rd, input logic [31:0] pc);
    in_valid    = iv;
    out_ready   = ordy;
    flush       = fl;
    regwriteIn  = rw;
    writeDataIn = data;
    registerIn  = rd;
    PCNEWIn     = pc;
  endtask

  // Apply the buffer rules to the model for one falling edge.
  task automatic model_edge();
    logic      acc;
    logic      rel;
    wb_entry_t e;
    acc = in_valid && (mq.size() < 2);
    rel = out_ready && (mq.size() > 0);
    if (!Reset_n || flush) begin
      mq.delete();
    end else begin
      if (rel) void'(mq.pop_front());
      if (acc) begin
        e.regwrite = regwriteIn && (registerIn != 5'd0);
        e.data     = writeDataIn;
        e.rd       = registerIn;
        e.pc       = PCNEWIn;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    wb_entry_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    chk("count",     64'(count),        64'(mq.size()));
    chk("in_ready",  64'(in_ready),     64'(mq.size() != 2));
    chk("out_valid", 64'(out_valid),    64'(mq.size() != 0));
    chk("regwrite",  64'(regwriteOut),  64'(h.regwrite));
    chk("data",      64'(writeDataOut), 64'(h.data));
    chk("reg",       64'(registerOut),  64'(h.rd));
    chk("pc",        64'(PCNEWOut),     64'(h.pc));
`ifdef WB_BYPASS_EN
    begin
      logic        hit;
      logic [31:0] bd;
      hit = 1'b0;
      bd  = 32'd0;
      if (bypassRegIn != 5'd0) begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (!hit && mq[i].regwrite && (mq[i].rd == bypassRegIn)) begin
            hit = 1'b1;
            bd  = mq[i].data;
          end
        end
      end
      chk("bypass_hit",  64'(bypassHit),     64'(hit));
      chk("bypass_data", 64'(bypassDataOut), 64'(bd));
    end
`endif
  endtask

  task automatic tick();
    @(negedge Clk);
    model_edge();
    @(posedge Clk);
    #1;
    check_model();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //            iv    or    fl    rw    data        rd     pc         cnt   rdy   rw    data        rd     pc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h101, 5'd1,  32'h100, 2'd1, 1'b1, 1'b1, 32'h101, 5'd1,  32'h100};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h102, 5'd2,  32'h104, 2'd2, 1'b0, 1'b1, 32'h101, 5'd1,  32'h100};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 5'd3,  32'h108, 2'd2, 1'b0, 1'b1, 32'h101, 5'd1,  32'h100};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 5'd3,  32'h108, 2'd1, 1'b1, 1'b1, 32'h102, 5'd2,  32'h104};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 5'd3,  32'h108, 2'd1, 1'b1, 1'b1, 32'h103, 5'd3,  32'h108};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   5'd0,  32'h0,   2'd0, 1'b1, 1'b0, 32'h0,   5'd0,  32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h55,  5'd0,  32'h10C, 2'd1, 1'b1, 1'b0, 32'h55,  5'd0,  32'h10C};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h11,  5'd7,  32'h110, 2'd1, 1'b1, 1'b1, 32'h11,  5'd7,  32'h110};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h99,  5'd9,  32'h114, 2'd2, 1'b0, 1'b1, 32'h11,  5'd7,  32'h110};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hAA,  5'd10, 32'h118, 2'd0, 1'b1, 1'b0, 32'h0,   5'd0,  32'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0,  32'h0,   2'd0, 1'b1, 1'b0, 32'h0,   5'd0,  32'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h77,  5'd12, 32'h11C, 2'd1, 1'b1, 1'b0, 32'h77,  5'd12, 32'h11C};

    Reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
    bypassRegIn = 5'd0;
`endif
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_count",     64'(count),        64'd0);
    chk("rst_in_ready",  64'(in_ready),     64'd1);
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_data",      64'(writeDataOut), 64'd0);
    Reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].rw, vecs[i].data, vecs[i].rd, vecs[i].pc);
      tick();
      chk($sformatf("vec%0d_count", i),    64'(count),        64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready),     64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_regwrite", i), 64'(regwriteOut),  64'(vecs[i].e_rw));
      chk($sformatf("vec%0d_data", i),     64'(writeDataOut), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d_reg", i),      64'(registerOut),  64'(vecs[i].e_rd));
      chk($sformatf("vec%0d_pc", i),       64'(PCNEWOut),     64'(vecs[i].e_pc));
    end

    // Reset asserted mid-stream with a full buffer takes effect immediately.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h201, 5'd11, 32'h200);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h202, 5'd12, 32'h204);
    tick();
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    Reset_n = 1'b0;
    mq.delete();
    #1;
    chk("mid_rst_count",     64'(count),        64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),     64'd1);
    chk("mid_rst_out_valid", 64'(out_valid),    64'd0);
    chk("mid_rst_regwrite",  64'(regwriteOut),  64'd0);
    chk("mid_rst_data",      64'(writeDataOut), 64'd0);
    chk("mid_rst_reg",       64'(registerOut),  64'd0);
    chk("mid_rst_pc",        64'(PCNEWOut),     64'd0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
    @(negedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 5'd5, 32'h40);
    tick();
    chk("post_rst_count", 64'(count),        64'd1);
    chk("post_rst_rw",    64'(regwriteOut),  64'd1);
    chk("post_rst_data",  64'(writeDataOut), 64'hDEADBEEF);
    chk("post_rst_reg",   64'(registerOut),  64'd5);
    chk("post_rst_pc",    64'(PCNEWOut),     64'h40);

`ifdef WB_BYPASS_EN
    // Youngest-first bypass selection with both entries writing reg 4.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 32'h0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'hAA, 5'd4, 32'h300);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'hBB, 5'd4, 32'h304);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
    bypassRegIn = 5'd4;
    #1;
    chk("byp4_hit",  64'(bypassHit),     64'd1);
    chk("byp4_data", 64'(bypassDataOut), 64'hBB);
    bypassRegIn = 5'd0;
    #1;
    chk("byp0_hit",  64'(bypassHit),     64'd0);
    chk("byp0_data", 64'(bypassDataOut), 64'd0);
`endif

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      set_in(1'($urandom_range(1, 0)),
             1'($urandom_range(3, 0) != 0),
             1'($urandom_range(15, 0) == 0),
             1'($urandom_range(1, 0)),
             $urandom(),
             5'($urandom_range(31, 0) < 4 ? 0 : $urandom_range(7, 1)),
             $urandom());
`ifdef WB_BYPASS_EN
      bypassRegIn = 5'($urandom_range(7, 0));
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
